instruction_fetch: RTL and testbench

Program sequencer that feeds the instruction decoder.
- Owns the program counter, the instruction-memory address and the 16-entry label table.
- Runs the two-pass program model: a label pass that records `stl` targets, then a run pass.
- Consumes the decoder's registered flags and the execute stage's branch result to pick the next PC.

---
 rtl/isa_pkg.sv | 34 +++
 rtl/label_table.sv | 51 +++++
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : Shared ISA opcodes, fetch-sequencer state encoding and sizing
//               constants for the instruction fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

  localparam int NUM_LABELS = 16;
  localparam int PC_W       = 8;

  typedef enum logic [3:0] {
    OP_CPT = 4'd0,
    OP_STL = 4'd7,
    OP_BLT = 4'd9,
    OP_HLT = 4'd14
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_t;

  // An instruction is in flight in any of the three pipeline phases.
  function automatic logic is_busy(input fetch_state_t s);
    return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_RESOLVE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/label_table.sv
`default_nettype none
// ============================================================================
// Module      : label_table
// Description : Label register file with per-entry valid bits; one synchronous
//               write port, one combinational read port, bulk valid clear.
// Revision    : 1.0 - initial release
// ============================================================================
module label_table #(
  parameter int NUM_LABELS = isa_pkg::NUM_LABELS,
  parameter int PC_W       = isa_pkg::PC_W,
  parameter int IDX_W      = $clog2(NUM_LABELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [PC_W-1:0]  i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [PC_W-1:0]  o_rd_data,
  output logic             o_rd_valid
);

  logic [PC_W-1:0]       w_data [NUM_LABELS];
  logic [NUM_LABELS-1:0] w_valid;

  for (genvar g = 0; g < NUM_LABELS; g++) begin : g_entry
    logic            r_v;
    logic [PC_W-1:0] r_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (i_clear) begin
        r_v <= 1'b0;
      end else if (i_wr_en && (i_wr_idx == IDX_W'(g))) begin
        r_v <= 1'b1;
        r_d <= i_wr_data;
      end
    end

    assign w_valid[g] = r_v;
    assign w_data[g]  = r_d;
  end

  assign o_rd_data  = w_data[i_rd_idx];
  assign o_rd_valid = w_valid[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Two-pass program sequencer: owns the PC and label table, issues
//               one instruction per FETCH/ISSUE/RESOLVE triplet to the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int NUM_LABELS = isa_pkg::NUM_LABELS,
  parameter int PC_W       = isa_pkg::PC_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [PC_W-1:0]               imem_addr,
  input  logic [7:0]                    imem_data,
  output logic [PC_W-1:0]               program_counter,
  output logic [7:0]                    instruction,
  output logic                          instrValid,
  output logic                          labelPassFlag,
  output logic                          pcResetPulse,
  input  logic                          labelFlag,
  input  logic [$clog2(NUM_LABELS)-1:0] labelIndex,
  input  logic [PC_W-1:0]               labelValue,
  input  logic                          branchTaken,
  input  logic [$clog2(NUM_LABELS)-1:0] branchLabel,
  input  logic                          haltFlag,
  input  logic                          pcResetFlag,
  output logic                          busy,
  output logic                          halted,
  output logic                          fault
);

  import isa_pkg::*;

  localparam int IDX_W = $clog2(NUM_LABELS);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] r_prog_ctr;
  logic [7:0]      r_instr;
  logic            r_label_pass;
  logic            w_label_pass_nxt;
  logic            r_pc_reset_pulse;
  logic            w_pulse_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic            w_tbl_clear;
  logic            w_tbl_wr;
  logic            w_tbl_hit;
  logic [PC_W-1:0] w_tbl_target;

  assign w_tbl_wr = (r_state == ST_RESOLVE) && r_label_pass && labelFlag;

  label_table #(
    .NUM_LABELS (NUM_LABELS),
    .PC_W       (PC_W),
    .IDX_W      (IDX_W)
  ) u_label_table (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_tbl_clear),
    .i_wr_en    (w_tbl_wr),
    .i_wr_idx   (labelIndex),
    .i_wr_data  (labelValue),
    .i_rd_idx   (branchLabel),
    .o_rd_data  (w_tbl_target),
    .o_rd_valid (w_tbl_hit)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_label_pass_nxt = r_label_pass;
    w_pulse_nxt      = 1'b0;
    w_fault_nxt      = r_fault;
    w_tbl_clear      = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_nxt      = ST_FETCH;
          w_pc_nxt         = '0;
          w_label_pass_nxt = 1'b1;
          w_fault_nxt      = 1'b0;
          w_tbl_clear      = 1'b1;
        end
      end
      ST_FETCH: w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESOLVE;
      ST_RESOLVE: begin
        w_state_nxt = ST_FETCH;
        // Pass-specific flags only act in their own pass; everything else steps.
        if (r_label_pass && pcResetFlag) begin
          w_pc_nxt         = '0;
          w_label_pass_nxt = 1'b0;
          w_pulse_nxt      = 1'b1;
        end else if (!r_label_pass && haltFlag) begin
          w_state_nxt = ST_HALTED;
        end else if (!r_label_pass && branchTaken) begin
          if (w_tbl_hit) begin
            w_pc_nxt = w_tbl_target;
          end else begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_HALTED;
          end
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc             <= '0;
      r_label_pass     <= 1'b0;
      r_pc_reset_pulse <= 1'b0;
      r_fault          <= 1'b0;
      r_prog_ctr       <= '0;
      r_instr          <= '0;
    end else begin
      r_pc             <= w_pc_nxt;
      r_label_pass     <= w_label_pass_nxt;
      r_pc_reset_pulse <= w_pulse_nxt;
      r_fault          <= w_fault_nxt;
      if (r_state == ST_FETCH) begin
        r_instr    <= imem_data;
        r_prog_ctr <= r_pc;
      end
    end
  end

  assign imem_addr       = r_pc;
  assign program_counter = r_prog_ctr;
  assign instruction     = r_instr;
  assign instrValid      = (r_state == ST_ISSUE);
  assign labelPassFlag   = r_label_pass;
  assign pcResetPulse    = r_pc_reset_pulse;
  assign busy            = is_busy(r_state);
  assign halted          = (r_state == ST_HALTED);
  assign fault           = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench with an instruction-level sequencer model,
//               a decoder/execute stand-in and directed plus random programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] imem_addr, imem_data, program_counter, instruction, labelValue;
  logic       instrValid, labelPassFlag, pcResetPulse, busy, halted, fault;
  logic       labelFlag, branchTaken, haltFlag, pcResetFlag;
  logic [3:0] labelIndex, branchLabel;

  logic [7:0] rom    [256];
  logic [7:0] lv_rom [256];

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .program_counter(program_counter), .instruction(instruction),
    .instrValid(instrValid), .labelPassFlag(labelPassFlag), .pcResetPulse(pcResetPulse),
    .labelFlag(labelFlag), .labelIndex(labelIndex), .labelValue(labelValue),
    .branchTaken(branchTaken), .branchLabel(branchLabel),
    .haltFlag(haltFlag), .pcResetFlag(pcResetFlag),
    .busy(busy), .halted(halted), .fault(fault)
  );

  // Program-level model of the sequencer.
  logic [7:0] m_pc, m_prev_pc, m_prev_instr;
  logic       m_pass, m_fault, m_halted, m_pulse;
  logic [7:0] m_tab [16];
  logic       m_tv  [16];
  logic       bt_force;

  logic [7:0] e_addr, e_pcout, e_instr;
  logic       e_valid, e_lpf, e_pulse, e_busy, e_halted, e_fault;
  logic       e_chk = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_chk) begin
      cmp("imem_addr", imem_addr, e_addr);
      cmp("program_counter", program_counter, e_pcout);
      cmp("instruction", instruction, e_instr);
      cmp("instrValid", {7'd0, instrValid}, {7'd0, e_valid});
      cmp("labelPassFlag", {7'd0, labelPassFlag}, {7'd0, e_lpf});
      cmp("pcResetPulse", {7'd0, pcResetPulse}, {7'd0, e_pulse});
      cmp("busy", {7'd0, busy}, {7'd0, e_busy});
      cmp("halted", {7'd0, halted}, {7'd0, e_halted});
      cmp("fault", {7'd0, fault}, {7'd0, e_fault});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp_idle();
    e_addr = m_pc; e_pcout = m_prev_pc; e_instr = m_prev_instr;
    e_valid = 1'b0; e_lpf = m_pass; e_pulse = 1'b0;
    e_busy = 1'b0; e_halted = m_halted; e_fault = m_fault;
  endtask

  task automatic set_exp_fetch();
    e_addr = m_pc; e_pcout = m_prev_pc; e_instr = m_prev_instr;
    e_valid = 1'b0; e_lpf = m_pass; e_pulse = m_pulse;
    e_busy = 1'b1; e_halted = 1'b0; e_fault = m_fault;
  endtask

  task automatic clear_dec();
    labelFlag = 1'b0; labelIndex = 4'd0; labelValue = 8'd0;
    branchTaken = 1'b0; branchLabel = 4'd0; haltFlag = 1'b0; pcResetFlag = 1'b0;
  endtask

  task automatic rand_dec();
    labelFlag   = 1'($urandom_range(0, 1));
    labelIndex  = 4'($urandom);
    labelValue  = 8'($urandom);
    branchTaken = 1'($urandom_range(0, 1));
    branchLabel = 4'($urandom);
    haltFlag    = 1'($urandom_range(0, 1));
    pcResetFlag = 1'($urandom_range(0, 1));
  endtask

  // Decoder/execute stand-in: flags for the instruction just issued.
  task automatic decode();
    logic [3:0] op, v;
    op = m_prev_instr[7:4];
    v  = m_prev_instr[3:0];
    rand_dec();
    labelFlag = 1'b0; branchTaken = 1'b0; haltFlag = 1'b0; pcResetFlag = 1'b0;
    if (m_pass) begin
      case (op)
        4'h7: begin labelFlag = 1'b1; labelIndex = v; labelValue = lv_rom[m_prev_pc]; end
        4'hE: pcResetFlag = 1'b1;
        4'h9: begin branchTaken = 1'($urandom_range(0, 1)); branchLabel = v; end
        default: ;
      endcase
    end else begin
      case (op)
        4'h7: begin labelFlag = 1'b1; labelIndex = v; end
        4'hE: haltFlag = 1'b1;
        4'h9: begin branchTaken = bt_force ? 1'b1 : 1'($urandom_range(0, 1)); branchLabel = v; end
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_prev_pc = 8'd0; m_prev_instr = 8'd0;
    m_pass = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_pulse = 1'b0;
    for (int i = 0; i < 16; i++) begin m_tv[i] = 1'b0; m_tab[i] = 8'd0; end
  endtask

  task automatic apply_resolve();
    if (m_pass && labelFlag) begin
      m_tab[labelIndex] = labelValue;
      m_tv[labelIndex]  = 1'b1;
    end
    if (m_pass && pcResetFlag) begin
      m_pc = 8'd0; m_pass = 1'b0; m_pulse = 1'b1;
    end else if (!m_pass && haltFlag) begin
      m_halted = 1'b1;
    end else if (!m_pass && branchTaken) begin
      if (m_tv[branchLabel]) m_pc = m_tab[branchLabel];
      else begin m_fault = 1'b1; m_halted = 1'b1; end
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i]    = 8'h00;
      lv_rom[i] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; clear_dec();
    model_reset(); set_exp_idle(); e_chk = 1'b1;
    tick(); tick();
    reset = 1'b0;
    set_exp_idle();
  endtask

  task automatic do_start();
    set_exp_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 8'd0; m_pass = 1'b1; m_fault = 1'b0; m_halted = 1'b0; m_pulse = 1'b0;
    for (int i = 0; i < 16; i++) m_tv[i] = 1'b0;
    set_exp_fetch();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin set_exp_idle(); tick(); end
    set_exp_idle();
  endtask

  // One FETCH/ISSUE/RESOLVE triplet; optionally an async reset inside RESOLVE.
  task automatic run_instr(input bit rst_mid);
    set_exp_fetch();
    rand_dec(); start = 1'($urandom_range(0, 1));
    tick();
    m_prev_pc = m_pc; m_prev_instr = rom[m_pc]; m_pulse = 1'b0;
    e_pcout = m_prev_pc; e_instr = m_prev_instr; e_valid = 1'b1; e_pulse = 1'b0;
    rand_dec(); start = 1'($urandom_range(0, 1));
    tick();
    e_valid = 1'b0;
    decode(); start = 1'($urandom_range(0, 1));
    if (rst_mid) begin
      #2 reset = 1'b1;
      #1;
      cmp("rst_imem_addr", imem_addr, 8'h00);
      cmp("rst_program_counter", program_counter, 8'h00);
      cmp("rst_instruction", instruction, 8'h00);
      cmp("rst_busy", {7'd0, busy}, 8'h00);
      cmp("rst_instrValid", {7'd0, instrValid}, 8'h00);
      cmp("rst_labelPassFlag", {7'd0, labelPassFlag}, 8'h00);
      cmp("rst_halted", {7'd0, halted}, 8'h00);
      model_reset(); set_exp_idle();
      start = 1'b0; clear_dec();
      tick();
      reset = 1'b0;
      return;
    end
    tick();
    start = 1'b0;
    apply_resolve();
    clear_dec();
    if (m_halted) set_exp_idle(); else set_exp_fetch();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] v;
    clear_dec(); model_reset(); clear_rom(); bt_force = 1'b1;
    #2 reset = 1'b1;
    tick();
    set_exp_idle(); e_chk = 1'b1;
    cmp("reset_imem_addr", imem_addr, 8'h00);
    cmp("reset_busy", {7'd0, busy}, 8'h00);
    cmp("reset_fault", {7'd0, fault}, 8'h00);
    tick();
    reset = 1'b0;
    set_exp_idle();

    // Label pass: stl 3 at PC 0, then pass-end marker.
    rom[0] = 8'h73; rom[1] = 8'hE0; lv_rom[0] = 8'h00;
    do_start();
    cmp("start_labelPassFlag", {7'd0, labelPassFlag}, 8'h01);
    run_instr(0); run_instr(0);
    cmp("lp_imem_addr", imem_addr, 8'h00);
    cmp("lp_flag_fell", {7'd0, labelPassFlag}, 8'h00);
    cmp("lp_pulse", {7'd0, pcResetPulse}, 8'h01);
    rom[0] = 8'h93;
    run_instr(0);
    cmp("lbl3_target", imem_addr, 8'h00);
    cmp("lbl3_no_fault", {7'd0, fault}, 8'h00);
    do_reset();

    // Taken branch to label 3 = 0x05, then branch to unwritten label 7.
    clear_rom();
    rom[0] = 8'h73; lv_rom[0] = 8'h05; rom[2] = 8'h93; rom[3] = 8'hE0; rom[5] = 8'h97;
    do_start();
    repeat (4) run_instr(0);
    repeat (3) run_instr(0);
    cmp("br_imem_addr", imem_addr, 8'h05);
    run_instr(0);
    cmp("br_issued_pc", program_counter, 8'h05);
    cmp("bad_lbl_fault", {7'd0, fault}, 8'h01);
    cmp("bad_lbl_halted", {7'd0, halted}, 8'h01);
    cmp("bad_lbl_pc_kept", imem_addr, 8'h05);
    idle(4);
    cmp("halted_not_busy", {7'd0, busy}, 8'h00);

    // Restart from HALTED, halt, restart with cleared table.
    clear_rom(); rom[1] = 8'hE0;
    do_start();
    cmp("restart_lpf", {7'd0, labelPassFlag}, 8'h01);
    cmp("restart_fault_clr", {7'd0, fault}, 8'h00);
    repeat (4) run_instr(0);
    cmp("halt_halted", {7'd0, halted}, 8'h01);
    idle(3);
    clear_rom(); rom[0] = 8'h93; rom[1] = 8'hE0;
    do_start();
    repeat (3) run_instr(0);
    cmp("cleared_tbl_fault", {7'd0, fault}, 8'h01);
    idle(2);

    // PC wrap 0xFF -> 0x00.
    do_reset();
    clear_rom(); rom[0] = 8'h71; lv_rom[0] = 8'hFF; rom[1] = 8'h91; rom[2] = 8'hE0;
    do_start();
    repeat (3) run_instr(0);
    repeat (2) run_instr(0);
    cmp("to_ff_addr", imem_addr, 8'hFF);
    run_instr(0);
    cmp("wrap_addr", imem_addr, 8'h00);
    do_reset();

    // Async reset during a label-write RESOLVE.
    clear_rom(); rom[0] = 8'h74; lv_rom[0] = 8'h20; rom[1] = 8'hE0;
    do_start();
    run_instr(1);
    rom[0] = 8'h94;
    do_start();
    repeat (3) run_instr(0);
    cmp("rst_no_write_fault", {7'd0, fault}, 8'h01);
    idle(2);

    // Random programs.
    bt_force = 1'b0;
    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        k = $urandom_range(0, 19);
        v = 4'($urandom);
        if (k < 13)      rom[i] = {4'($urandom_range(0, 6)), v};
        else if (k < 15) rom[i] = {4'h7, v};
        else if (k < 19) rom[i] = {4'h9, v};
        else             rom[i] = {4'hE, v};
        lv_rom[i] = 8'($urandom);
      end
      for (int r = 0; r < 2; r++) begin
        do_start();
        for (int n = 0; n < 150 && !m_halted; n++) run_instr(0);
        if (m_halted) idle(2);
        else run_instr(1);
      end
    end

    e_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
